// File: rtl/stream_mem_bridge_pkg.sv
// Shared definitions for the byte-stream to banked-memory bridge:
// header op codes, FSM state encoding and header bit positions.
package stream_mem_bridge_pkg;

    typedef enum logic [1:0] {
        OpWrite  = 2'b00,
        OpRead   = 2'b01,
        OpStart  = 2'b10,
        OpStatus = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StAddrH      = 4'd1,
        StAddrL      = 4'd2,
        StLenH       = 4'd3,
        StLenL       = 4'd4,
        StWrData     = 4'd5,
        StRdIssue    = 4'd6,
        StRdWait     = 4'd7,
        StRdSend     = 4'd8,
        StStatusSend = 4'd9
    } state_e;

    localparam int unsigned HdrOpMsb   = 7;
    localparam int unsigned HdrOpLsb   = 6;
    localparam int unsigned HdrBankMsb = 2;
    localparam int unsigned HdrBankLsb = 0;
    localparam int unsigned BankW      = HdrBankMsb - HdrBankLsb + 1;

endpackage

// File: rtl/stream_mem_bridge_sticky_flags.sv
// Per-bank sticky completion flags: set by a done pulse, cleared by a start
// pulse; clear wins when both arrive in the same cycle.
module sticky_flags #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] flags
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags <= (flags | set) & ~clear;
        end
    end

endmodule

// File: rtl/stream_mem_bridge.sv
// Decodes a byte command stream into banked memory writes/reads, per-bank
// start pulses and a done-status query; responses go out on the source stream.
module stream_mem_bridge
    import stream_mem_bridge_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 3,
    parameter int unsigned ADDR_W    = 16,
    parameter logic [7:0]  FILL_BYTE = 8'h4A
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sink_valid,
    output logic                   sink_ready,
    input  logic [7:0]             sink_data,
    output logic                   source_valid,
    input  logic                   source_ready,
    output logic [7:0]             source_data,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_wdata,
    output logic [NUM_BANKS-1:0]   mem_we,
    input  logic [8*NUM_BANKS-1:0] mem_rdata,
    output logic [NUM_BANKS-1:0]   start,
    input  logic [NUM_BANKS-1:0]   done,
    output logic                   busy,
    output logic [3:0]             state_out
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [BankW-1:0]    bank_q, bank_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [7:0]          mem_wdata_d;
    logic [NUM_BANKS-1:0] mem_we_d;
    logic [NUM_BANKS-1:0] start_d;
    logic                source_valid_d;
    logic [7:0]          source_data_d;
    logic [NUM_BANKS-1:0] done_latch;
    logic                sink_fire;
    op_e                 hdr_op;
    logic [BankW-1:0]    hdr_bank;
    logic [7:0]          rd_byte;

    // Out-of-range banks decode to an all-zero vector, which suppresses
    // writes and start pulses without any extra qualification.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BankW-1:0] b);
        logic [NUM_BANKS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            oh[i] = (b == BankW'(i));
        end
        return oh;
    endfunction

    assign sink_ready = state_q inside {StIdle, StAddrH, StAddrL, StLenH, StLenL, StWrData};
    assign sink_fire  = sink_valid && sink_ready;
    assign hdr_op     = op_e'(sink_data[HdrOpMsb:HdrOpLsb]);
    assign hdr_bank   = sink_data[HdrBankMsb:HdrBankLsb];
    assign busy       = (state_q != StIdle);
    assign state_out  = state_q;

    always_comb begin
        rd_byte = FILL_BYTE;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_q == BankW'(i)) begin
                rd_byte = mem_rdata[8*i +: 8];
            end
        end
    end

    sticky_flags #(
        .WIDTH (NUM_BANKS)
    ) u_done_flags (
        .clk   (clk),
        .reset (reset),
        .set   (done),
        .clear (start),
        .flags (done_latch)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        bank_d         = bank_q;
        hi_d           = hi_q;
        addr_d         = addr_q;
        len_d          = len_q;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        mem_we_d       = '0;
        start_d        = '0;
        source_valid_d = source_valid;
        source_data_d  = source_data;

        unique case (state_q)
            StIdle: begin
                if (sink_fire) begin
                    op_d   = hdr_op;
                    bank_d = hdr_bank;
                    unique case (hdr_op)
                        OpWrite, OpRead: state_d = StAddrH;
                        OpStart:         start_d = bank_onehot(hdr_bank);
                        OpStatus:        state_d = StStatusSend;
                        default:         state_d = StIdle;
                    endcase
                end
            end
            StAddrH: begin
                if (sink_fire) begin
                    hi_d    = sink_data;
                    state_d = StAddrL;
                end
            end
            StAddrL: begin
                if (sink_fire) begin
                    addr_d  = ADDR_W'({hi_q, sink_data});
                    state_d = StLenH;
                end
            end
            StLenH: begin
                if (sink_fire) begin
                    hi_d    = sink_data;
                    state_d = StLenL;
                end
            end
            StLenL: begin
                if (sink_fire) begin
                    len_d   = {hi_q, sink_data};
                    state_d = (op_q == OpWrite) ? StWrData : StRdIssue;
                end
            end
            StWrData: begin
                if (sink_fire) begin
                    mem_we_d    = bank_onehot(bank_q);
                    mem_addr_d  = addr_q;
                    mem_wdata_d = sink_data;
                    addr_d      = addr_q + 1'b1;
                    len_d       = len_q - 1'b1;
                    if (len_q == 16'd0) begin
                        state_d = StIdle;
                    end
                end
            end
            StRdIssue: begin
                mem_addr_d = addr_q;
                state_d    = StRdWait;
            end
            StRdWait: begin
                state_d = StRdSend;
            end
            StRdSend: begin
                // First cycle captures the bank data; afterwards hold until taken.
                if (!source_valid) begin
                    source_valid_d = 1'b1;
                    source_data_d  = rd_byte;
                end else if (source_ready) begin
                    source_valid_d = 1'b0;
                    addr_d         = addr_q + 1'b1;
                    len_d          = len_q - 1'b1;
                    state_d        = (len_q == 16'd0) ? StIdle : StRdIssue;
                end
            end
            StStatusSend: begin
                if (!source_valid) begin
                    source_valid_d = 1'b1;
                    source_data_d  = 8'(done_latch);
                end else if (source_ready) begin
                    source_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= OpWrite;
            bank_q       <= '0;
            hi_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= '0;
            start        <= '0;
            source_valid <= 1'b0;
            source_data  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bank_q       <= bank_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_we       <= mem_we_d;
            start        <= start_d;
            source_valid <= source_valid_d;
            source_data  <= source_data_d;
        end
    end

endmodule

// File: tb/tb_stream_mem_bridge.sv
// Directed bench for stream_mem_bridge: drives command bytes, models three
// 1-cycle-latency memory banks and checks writes, reads, start and status.
module tb_stream_mem_bridge;

    localparam int unsigned NB = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sink_valid = 1'b0;
    logic          sink_ready;
    logic [7:0]    sink_data = 8'h00;
    logic          source_valid;
    logic          source_ready = 1'b0;
    logic [7:0]    source_data;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic [NB-1:0] mem_we;
    logic [8*NB-1:0] mem_rdata;
    logic [NB-1:0] start;
    logic [NB-1:0] done = '0;
    logic          busy;
    logic [3:0]    state_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [NB][65536];
    logic [7:0]  rd [NB];
    logic [26:0] wlog [$];

    always #5 clk = ~clk;

    stream_mem_bridge #(
        .NUM_BANKS (NB),
        .ADDR_W    (16),
        .FILL_BYTE (8'h4A)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_data    (sink_data),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .start        (start),
        .done         (done),
        .busy         (busy),
        .state_out    (state_out)
    );

    // Bank memories plus a log of every write strobe seen at a clock edge.
    always @(posedge clk) begin
        if (reset) begin
            mem[2][16'hFFFF] <= 8'h5C;
            mem[2][16'h0000] <= 8'hA3;
            mem[0][16'h0100] <= 8'h11;
            mem[0][16'h0101] <= 8'h22;
        end
        for (int i = 0; i < NB; i++) begin
            if (mem_we[i]) mem[i][mem_addr] <= mem_wdata;
            rd[i] <= mem[i][mem_addr];
        end
        if (mem_we !== '0) wlog.push_back({mem_we, mem_addr, mem_wdata});
    end

    assign mem_rdata = {rd[2], rd[1], rd[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        sink_valid = 1'b1;
        sink_data  = b;
        while (!sink_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sink_ready) check("sink_ready_timeout", 32'(sink_ready), 32'd1);
        @(posedge clk); #1;
        sink_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] hdr, input logic [15:0] addr,
                            input logic [15:0] len_m1);
        send_byte(hdr);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(len_m1[15:8]);
        send_byte(len_m1[7:0]);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        int n = 0;
        source_ready = 1'b1;
        while (!source_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!source_valid) begin
            check("source_valid_timeout", 32'(source_valid), 32'd1);
            d = 8'hxx;
            source_ready = 1'b0;
            return;
        end
        d = source_data;
        @(posedge clk); #1;
        source_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int n;

        // Reset values
        #1;
        check("rst_source_valid", 32'(source_valid), 32'd0);
        check("rst_source_data", 32'(source_data), 32'h00);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_sink_ready", 32'(sink_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // WRITE bank1 (reserved header bits set) addr 0x0010, three bytes
        wlog.delete();
        send_cmd(8'h39, 16'h0010, 16'h0002);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_state", 32'(state_out), 32'd5);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wr_count", 32'(wlog.size()), 32'd3);
        check("wr0", 32'(wlog[0]), 32'({3'b010, 16'h0010, 8'hAA}));
        check("wr1", 32'(wlog[1]), 32'({3'b010, 16'h0011, 8'hBB}));
        check("wr2", 32'(wlog[2]), 32'({3'b010, 16'h0012, 8'hCC}));
        check("wr_idle", 32'(busy), 32'd0);

        // READ bank2 addr 0xFFFF, two bytes, with a 5-cycle stall
        send_cmd(8'h42, 16'hFFFF, 16'h0001);
        n = 0;
        while (!source_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_first_valid", 32'(source_valid), 32'd1);
        check("rd_first_data", 32'(source_data), 32'h5C);
        check("rd_sink_blocked", 32'(sink_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rd_stall_valid", 32'(source_valid), 32'd1);
            check("rd_stall_data", 32'(source_data), 32'h5C);
        end
        recv_byte(d);
        check("rd_byte0", 32'(d), 32'h5C);
        recv_byte(d);
        check("rd_byte1_wrap", 32'(d), 32'hA3);
        check("rd_idle", 32'(busy), 32'd0);

        // START bank0, done pulse, STATUS, restart, STATUS
        send_byte(8'h80);
        check("start_pulse", 32'(start), 32'd1);
        @(posedge clk); #1;
        check("start_cleared", 32'(start), 32'd0);
        done = 3'b001;
        @(posedge clk); #1;
        done = 3'b000;
        send_byte(8'hC0);
        recv_byte(d);
        check("status_done0", 32'(d), 32'h01);
        send_byte(8'h80);
        send_byte(8'hC0);
        recv_byte(d);
        check("status_after_restart", 32'(d), 32'h00);

        // done[2] and start[2] in the same cycle: clear wins
        done = 3'b100;
        @(posedge clk); #1;
        done = 3'b000;
        send_byte(8'hC0);
        recv_byte(d);
        check("status_done2", 32'(d), 32'h04);
        send_byte(8'h82);
        check("start2_pulse", 32'(start), 32'd4);
        done = 3'b100;
        @(posedge clk); #1;
        done = 3'b000;
        send_byte(8'hC0);
        recv_byte(d);
        check("status_collide", 32'(d), 32'h00);

        // Nonexistent bank: READ returns fill, START does nothing
        wlog.delete();
        send_cmd(8'h45, 16'h0000, 16'h0003);
        for (int i = 0; i < 4; i++) begin
            recv_byte(d);
            check("fill_byte", 32'(d), 32'h4A);
        end
        send_byte(8'h85);
        check("start_bank5", 32'(start), 32'd0);
        check("fill_no_we", 32'(wlog.size()), 32'd0);

        // Reset after the second WRITE data byte
        wlog.delete();
        send_cmd(8'h00, 16'h0200, 16'h0003);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        #1;
        check("mid_rst_source_valid", 32'(source_valid), 32'd0);
        check("mid_rst_source_data", 32'(source_data), 32'h00);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("mid_rst_start", 32'(start), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(state_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_wlog", 32'(wlog.size()), 32'd1);
        check("mid_rst_wr0", 32'(wlog[0]), 32'({3'b001, 16'h0200, 8'h01}));
        send_cmd(8'h40, 16'h0100, 16'h0001);
        recv_byte(d);
        check("post_rst_rd0", 32'(d), 32'h11);
        recv_byte(d);
        check("post_rst_rd1", 32'(d), 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
